slot_multi: RTL and testbench

Multi-reel slot machine: N_REELS decimal reels spin together on a shared, slow enable tick. Each reel is frozen by its own stop button, and a match is flagged once every reel has stopped. Each reel drives one 7-segment digit. It supersedes the single free-running reel and reuses the existing tick generator, mod-10 counter and decimal decoder behaviour.

---
 rtl/slot_multi.sv | 125 ++++++++++++
 tb/tb_slot_multi.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/slot_multi.sv
// Multi-reel slot machine: decimal reels spin on a shared prescaler tick, each frozen by its own stop button.
// Optional win-blink feature is enabled by defining SLOT_MULTI_BLINK_EN.
module slot_multi #(
  parameter int EN_CYCLE = 22,
  parameter int N_REELS  = 3
) (
  input  logic                   clk,
  input  logic                   i_sclr,
  input  logic                   i_start,
  input  logic [N_REELS-1:0]     i_stop,
  output logic [7*N_REELS-1:0]   o_hex,
  output logic                   o_running,
  output logic                   o_win
);

  typedef enum logic [1:0] {IDLE, SPIN, RESULT} state_t;

  state_t               r_state;
  state_t               w_nextState;
  logic [EN_CYCLE-1:0]  r_presc;
  logic                 w_tick;
  logic [3:0]           r_reel [N_REELS];
  logic [N_REELS-1:0]   r_stop;
  logic                 r_running;
  logic                 r_win;
  logic                 w_allEqual;
  logic                 w_blank;

  function automatic logic [6:0] segOf(input logic [3:0] digit);
    case (digit)
      4'd0:    segOf = 7'b1000000;
      4'd1:    segOf = 7'b1111001;
      4'd2:    segOf = 7'b0100100;
      4'd3:    segOf = 7'b0110000;
      4'd4:    segOf = 7'b0011001;
      4'd5:    segOf = 7'b0010010;
      4'd6:    segOf = 7'b0000010;
      4'd7:    segOf = 7'b1111000;
      4'd8:    segOf = 7'b0000000;
      4'd9:    segOf = 7'b0010000;
      default: segOf = 7'b1111111;
    endcase
  endfunction

  // Free-running prescaler; never gated by state so tick phase is independent of i_start.
  always_ff @(posedge clk) begin
    if (i_sclr) r_presc <= '0;
    else        r_presc <= r_presc + 1'b1;
  end

  assign w_tick = &r_presc;

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (i_start) w_nextState = SPIN;
      SPIN:    if (&r_stop) w_nextState = RESULT;
      RESULT:  if (i_start) w_nextState = SPIN;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_allEqual = 1'b1;
    for (int k = 1; k < N_REELS; k++) begin
      if (r_reel[k] != r_reel[0]) w_allEqual = 1'b0;
    end
  end

  // A fresh spin clears stop flags and the previous win; the win is latched once on entering RESULT.
  always_ff @(posedge clk) begin
    if (i_sclr) begin
      r_state   <= IDLE;
      r_stop    <= '0;
      r_running <= 1'b0;
      r_win     <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_running <= (w_nextState == SPIN);
      if (r_state != SPIN && w_nextState == SPIN) begin
        r_stop <= '0;
        r_win  <= 1'b0;
      end else if (r_state == SPIN) begin
        r_stop <= r_stop | i_stop;
        if (w_nextState == RESULT) r_win <= w_allEqual;
      end
    end
  end

  // A stop request arriving on a tick edge wins over the increment.
  always_ff @(posedge clk) begin
    for (int k = 0; k < N_REELS; k++) begin
      if (i_sclr) begin
        r_reel[k] <= 4'(k % 10);
      end else if (r_state == SPIN && w_tick && !r_stop[k] && !i_stop[k]) begin
        r_reel[k] <= (r_reel[k] == 4'd9) ? 4'd0 : r_reel[k] + 4'd1;
      end
    end
  end

`ifdef SLOT_MULTI_BLINK_EN
  logic r_blink;

  always_ff @(posedge clk) begin
    if (i_sclr)                                        r_blink <= 1'b0;
    else if (r_state == RESULT && w_nextState != RESULT) r_blink <= 1'b0;
    else if (r_state == RESULT && r_win && w_tick)      r_blink <= ~r_blink;
  end

  assign w_blank = r_blink;
`else
  assign w_blank = 1'b0;
`endif

  always_comb begin
    o_hex = '1;
    for (int k = 0; k < N_REELS; k++) begin
      o_hex[7*k +: 7] = w_blank ? 7'b1111111 : segOf(r_reel[k]);
    end
  end

  assign o_running = r_running;
  assign o_win     = r_win;

endmodule

// File: tb/tb_slot_multi.sv
// Self-checking bench for slot_multi (N_REELS=3, EN_CYCLE=2) with a behavioural reference model.
module tb_slot_multi;

  localparam int EN_CYCLE = 2;
  localparam int N_REELS  = 3;
  localparam int PERIOD   = 1 << EN_CYCLE;

  logic         clk = 1'b0;
  logic         i_sclr = 1'b0;
  logic         i_start = 1'b0;
  logic [2:0]   i_stop = 3'b000;
  logic [20:0]  o_hex;
  logic         o_running;
  logic         o_win;

  int checkCount = 0;
  int passCount  = 0;

  // Reference model: cycles since reset, game mode (0 idle, 1 spinning, 2 result), plain-int reels.
  int       mCount;
  int       mMode;
  int       mReel [3];
  bit [2:0] mStop;
  bit       mRun;
  bit       mWin;
  bit       mBlink;

  logic [6:0] segTab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  slot_multi #(.EN_CYCLE(EN_CYCLE), .N_REELS(N_REELS)) dut (
    .clk       (clk),
    .i_sclr    (i_sclr),
    .i_start   (i_start),
    .i_stop    (i_stop),
    .o_hex     (o_hex),
    .o_running (o_running),
    .o_win     (o_win)
  );

  always #5 clk = ~clk;

  function automatic logic [20:0] expHex();
    logic [20:0] h;
    bit          blank;
`ifdef SLOT_MULTI_BLINK_EN
    blank = mBlink;
`else
    blank = 1'b0;
`endif
    for (int k = 0; k < 3; k++) h[7*k +: 7] = blank ? 7'h7f : segTab[mReel[k]];
    return h;
  endfunction

  function automatic logic [20:0] hexOf(input int d0, input int d1, input int d2);
    return {segTab[d2], segTab[d1], segTab[d0]};
  endfunction

  task automatic modelEdge(input bit sclr, input bit start, input bit [2:0] stop);
    bit tick;
    bit allStopped;
    tick = (mCount % PERIOD) == PERIOD - 1;
    if (sclr) begin
      mCount = 0; mMode = 0; mStop = 0; mRun = 0; mWin = 0; mBlink = 0;
      for (int k = 0; k < 3; k++) mReel[k] = k % 10;
      return;
    end
    mCount++;
    case (mMode)
      0: if (start) begin mMode = 1; mStop = 0; mWin = 0; end
      1: begin
        allStopped = (mStop == 3'b111);
        for (int k = 0; k < 3; k++)
          if (tick && !mStop[k] && !stop[k]) mReel[k] = (mReel[k] + 1) % 10;
        mStop = mStop | stop;
        if (allStopped) begin
          mMode = 2;
          mWin  = (mReel[0] == mReel[1]) && (mReel[1] == mReel[2]);
        end
      end
      default: begin
        if (start) begin mMode = 1; mStop = 0; mWin = 0; mBlink = 0; end
        else if (mWin && tick) mBlink = !mBlink;
      end
    endcase
    mRun = (mMode == 1);
  endtask

  task automatic cycle(input bit sclr, input bit start, input logic [2:0] stop);
    i_sclr = sclr; i_start = start; i_stop = stop;
    @(posedge clk);
    modelEdge(sclr, start, stop);
    #1;
  endtask

  task automatic test_reset();
    cycle(1, 0, 3'b000);
    checkCount++;
    if (o_hex !== hexOf(0, 1, 2)) $display("[TB] FAIL reset_hex got %h want %h", o_hex, hexOf(0, 1, 2));
    else passCount++;
    checkCount++;
    if (o_running !== 1'b0 || o_win !== 1'b0) $display("[TB] FAIL reset_flags got run=%b win=%b want 0 0", o_running, o_win);
    else passCount++;
    repeat (20) cycle(0, 0, 3'b000);
    checkCount++;
    if (o_hex !== hexOf(0, 1, 2) || o_running !== 1'b0) $display("[TB] FAIL idle_hold got hex=%h run=%b want %h 0", o_hex, o_running, hexOf(0, 1, 2));
    else passCount++;
  endtask

  task automatic test_spin();
    cycle(0, 1, 3'b000);
    checkCount++;
    if (o_running !== 1'b1) $display("[TB] FAIL spin_running got %b want 1", o_running);
    else passCount++;
    repeat (12) cycle(0, 0, 3'b000);
    checkCount++;
    if (o_hex !== hexOf(3, 4, 5)) $display("[TB] FAIL spin_3ticks got %h want %h", o_hex, hexOf(3, 4, 5));
    else passCount++;
    checkCount++;
    if (o_hex !== expHex()) $display("[TB] FAIL spin_model got %h want %h", o_hex, expHex());
    else passCount++;
  endtask

  task automatic test_stop_on_tick();
    int guard = 0;
    while ((mCount % PERIOD) != PERIOD - 1 && guard < 8) begin
      cycle(0, 0, 3'b000);
      guard++;
    end
    cycle(0, 0, 3'b001);
    checkCount++;
    if (o_hex !== hexOf(3, 5, 6)) $display("[TB] FAIL stop_on_tick got %h want %h", o_hex, hexOf(3, 5, 6));
    else passCount++;
    cycle(0, 0, 3'b110);
    checkCount++;
    if (o_running !== 1'b1) $display("[TB] FAIL last_stop_edge got run=%b want 1", o_running);
    else passCount++;
    cycle(0, 0, 3'b000);
    checkCount++;
    if (o_running !== 1'b0 || o_win !== 1'b0 || o_hex !== hexOf(3, 5, 6))
      $display("[TB] FAIL result_entry got run=%b win=%b hex=%h want 0 0 %h", o_running, o_win, o_hex, hexOf(3, 5, 6));
    else passCount++;
  endtask

  task automatic test_win();
    logic [2:0] stop;
    int guard = 0;
    cycle(1, 0, 3'b000);
    cycle(0, 1, 3'b000);
    while (mMode != 2 && guard < 60) begin
      for (int k = 0; k < 3; k++) stop[k] = (mReel[k] == 5);
      cycle(0, 0, stop);
      guard++;
      checkCount++;
      if (o_hex !== expHex()) $display("[TB] FAIL win_spin_hex got %h want %h", o_hex, expHex());
      else passCount++;
    end
    checkCount++;
    if (o_win !== 1'b1 || o_running !== 1'b0) $display("[TB] FAIL win_flag got win=%b run=%b want 1 0", o_win, o_running);
    else passCount++;
    for (int i = 0; i < 16; i++) begin
      cycle(0, 0, $urandom_range(0, 7));
      checkCount++;
      if (o_hex !== expHex() || o_win !== 1'b1)
        $display("[TB] FAIL win_hold got hex=%h win=%b want %h 1", o_hex, o_win, expHex());
      else passCount++;
    end
  endtask

  task automatic test_lose();
    int guard = 0;
    cycle(1, 0, 3'b000);
    cycle(0, 1, 3'b000);
    repeat (12) cycle(0, 0, 3'b000);
    cycle(0, 0, 3'b111);
    cycle(0, 0, 3'b000);
    checkCount++;
    if (o_win !== 1'b0 || o_running !== 1'b0 || o_hex !== hexOf(3, 4, 5))
      $display("[TB] FAIL lose_result got win=%b run=%b hex=%h want 0 0 %h", o_win, o_running, o_hex, hexOf(3, 4, 5));
    else passCount++;
    cycle(0, 1, 3'b000);
    checkCount++;
    if (o_running !== 1'b1 || o_win !== 1'b0) $display("[TB] FAIL restart got run=%b win=%b want 1 0", o_running, o_win);
    else passCount++;
    while (mReel[0] == 3 && guard < 8) begin
      cycle(0, 0, 3'b000);
      guard++;
    end
    checkCount++;
    if (o_hex !== hexOf(4, 5, 6)) $display("[TB] FAIL resume got %h want %h", o_hex, hexOf(4, 5, 6));
    else passCount++;
  endtask

  task automatic test_reset_mid_spin();
    cycle(0, 1, 3'b000);
    repeat (5) cycle(0, 0, 3'b000);
    cycle(1, 1, 3'b111);
    checkCount++;
    if (o_hex !== hexOf(0, 1, 2) || o_running !== 1'b0 || o_win !== 1'b0)
      $display("[TB] FAIL reset_mid_spin got hex=%h run=%b win=%b want %h 0 0", o_hex, o_running, o_win, hexOf(0, 1, 2));
    else passCount++;
    cycle(0, 0, 3'b000);
    checkCount++;
    if (o_running !== 1'b0) $display("[TB] FAIL reset_overrides_start got run=%b want 0", o_running);
    else passCount++;
  endtask

  task automatic test_random();
    bit         sclr;
    bit         start;
    logic [2:0] stop;
    cycle(1, 0, 3'b000);
    for (int i = 0; i < 600; i++) begin
      sclr  = ($urandom % 150) == 0;
      start = ($urandom % 25) == 0;
      stop  = 3'($urandom) & 3'($urandom) & 3'($urandom);
      cycle(sclr, start, stop);
      checkCount++;
      if (o_hex !== expHex() || o_running !== mRun || o_win !== mWin)
        $display("[TB] FAIL random_step%0d got hex=%h run=%b win=%b want %h %b %b",
                 i, o_hex, o_running, o_win, expHex(), mRun, mWin);
      else passCount++;
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_spin();
    test_stop_on_tick();
    test_win();
    test_lose();
    test_reset_mid_spin();
    test_random();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
